// File: rtl/led_counter_if.sv
// LED counter output bundle: registered LED value and the once-per-period tick.
interface led_counter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] leds;
    logic             tick;

    modport master (output leds, output tick);
    modport slave  (input  leds, input  tick);
endinterface

// File: rtl/led_counter.sv
// Free-running LED counter: a prescaler divides clk to one tick per CLK_FREQ cycles, each tick advances leds.
// Define LED_COUNTER_SATURATE_EN to make leds stop at all-ones instead of wrapping.
module led_counter #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int WIDTH    = 8
) (
    input  logic            clk,
    input  logic            rst,
    led_counter_if.master   led_bus
);
    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] leds_q, leds_d;
    logic             tick_q, tick_d;
    logic             wrap;

    always_comb begin
        wrap    = (presc_q == PRESC_MAX);
        presc_d = wrap ? '0 : presc_q + PW'(1);
        tick_d  = wrap;
        leds_d  = leds_q;
        if (wrap) begin
`ifdef LED_COUNTER_SATURATE_EN
            // All LEDs on is a terminal state until the next reset.
            if (leds_q != '1) begin
                leds_d = leds_q + WIDTH'(1);
            end
`else
            leds_d = leds_q + WIDTH'(1);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            leds_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            leds_q  <= leds_d;
            tick_q  <= tick_d;
        end
    end

    assign led_bus.leds = leds_q;
    assign led_bus.tick = tick_q;
endmodule

// File: tb/tb_led_counter.sv
// Directed bench for led_counter: three instances (CLK_FREQ 10, 2, 1) checked through an expectation queue.
`timescale 1ns/1ps
module tb_led_counter;
    typedef struct {
        string      tag;
        int         dut;
        logic [7:0] leds;
        logic       tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst10 = 1'b1, rst2 = 1'b1, rst1 = 1'b1;

    led_counter_if #(.WIDTH(8)) if10 ();
    led_counter_if #(.WIDTH(8)) if2  ();
    led_counter_if #(.WIDTH(8)) if1  ();

    led_counter #(.CLK_FREQ(10), .WIDTH(8)) u10 (.clk(clk), .rst(rst10), .led_bus(if10));
    led_counter #(.CLK_FREQ(2),  .WIDTH(8)) u2  (.clk(clk), .rst(rst2),  .led_bus(if2));
    led_counter #(.CLK_FREQ(1),  .WIDTH(8)) u1  (.clk(clk), .rst(rst1),  .led_bus(if1));

    always #5 clk = ~clk;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int e10 = 0, e2 = 0, e1 = 0;
    int t10 = 0, t1 = 0, dbl10 = 0;
    logic prev10 = 1'b0;

    function automatic logic [7:0] model_leds(int edges, int cf);
        int n;
        n = edges / cf;
`ifdef LED_COUNTER_SATURATE_EN
        if (n > 255) return 8'hFF;
        return 8'(n);
`else
        return 8'(n % 256);
`endif
    endfunction

    function automatic logic model_tick(int edges, int cf);
        return (edges > 0) && ((edges % cf) == 0);
    endfunction

    task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(string tag, int dut, logic [7:0] l, logic t);
        exp_t e;
        e.tag = tag; e.dut = dut; e.leds = l; e.tick = t;
        sb.push_back(e);
    endtask

    // Expectation for the instance's state n edges from now, counted from its last release.
    task automatic expect_after(string tag, int dut, int n);
        int edges;
        int cf;
        case (dut)
            10: begin edges = e10 + n; cf = 10; end
            2:  begin edges = e2 + n;  cf = 2;  end
            default: begin edges = e1 + n; cf = 1; end
        endcase
        push_exp(tag, dut, model_leds(edges, cf), model_tick(edges, cf));
    endtask

    task automatic check_sb();
        exp_t e;
        logic [7:0] l;
        logic t;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                10: begin l = if10.leds; t = if10.tick; end
                2:  begin l = if2.leds;  t = if2.tick;  end
                default: begin l = if1.leds; t = if1.tick; end
            endcase
            cmp({e.tag, "_leds"}, {24'b0, l}, {24'b0, e.leds});
            cmp({e.tag, "_tick"}, {31'b0, t}, {31'b0, e.tick});
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (!rst10) e10++;
            if (!rst2)  e2++;
            if (!rst1)  e1++;
            if (if10.tick === 1'b1) begin
                t10++;
                if (prev10) dbl10++;
            end
            prev10 = (if10.tick === 1'b1);
            if (if1.tick === 1'b1) t1++;
        end
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog expired before the directed sequence completed");
        $fatal(1, "timeout");
    end

    initial begin
        run(2);
        push_exp("rst10", 10, 8'd0, 1'b0);
        push_exp("rst2", 2, 8'd0, 1'b0);
        push_exp("rst1", 1, 8'd0, 1'b0);
        check_sb();

        // First period after release on CLK_FREQ=10.
        rst10 = 1'b0; e10 = 0; t10 = 0; prev10 = 1'b0;
        expect_after("t1_e9", 10, 9);
        run(9);
        check_sb();
        expect_after("t1_e10", 10, 1);
        run(1);
        check_sb();
        expect_after("t1_e15", 10, 5);
        run(5);
        check_sb();
        cmp("t1_tick_count", t10, 1);

        // Reset mid-count discards partial prescaler progress.
        rst10 = 1'b1;
        run(1);
        push_exp("t2_in_rst", 10, 8'd0, 1'b0);
        check_sb();
        rst10 = 1'b0; e10 = 0;
        run(5);
        rst10 = 1'b1;
        run(1);
        rst10 = 1'b0; e10 = 0; t10 = 0; dbl10 = 0; prev10 = 1'b0;
        expect_after("t2_e9", 10, 9);
        run(9);
        check_sb();
        expect_after("t2_e10", 10, 1);
        run(1);
        check_sb();
        expect_after("t2_e50", 10, 40);
        run(40);
        check_sb();
        cmp("t2_tick_count", t10, 5);
        cmp("t2_tick_wide", dbl10, 0);

        // Asynchronous reset between edges with leds=3 and tick high.
        rst2 = 1'b0; e2 = 0;
        expect_after("t3_pre", 2, 6);
        run(6);
        check_sb();
        #2;
        rst2 = 1'b1;
        #1;
        push_exp("t3_async", 2, 8'd0, 1'b0);
        check_sb();
        run(1);

        // Full LED range on CLK_FREQ=2: wrap (or saturate) at edge 512.
        rst2 = 1'b0; e2 = 0;
        expect_after("t4_e510", 2, 510);
        run(510);
        check_sb();
        expect_after("t4_e512", 2, 2);
        run(2);
        check_sb();
        expect_after("t4_e532", 2, 20);
        run(20);
        check_sb();

        // CLK_FREQ=1: increments every edge, tick continuously high.
        push_exp("t5_in_rst", 1, 8'd0, 1'b0);
        check_sb();
        rst1 = 1'b0; e1 = 0; t1 = 0;
        expect_after("t5_e7", 1, 7);
        run(7);
        check_sb();
        cmp("t5_tick_count", t1, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/led_counter.md
Name: led_counter

Overview:
- Free-running 8-bit LED counter: increments `leds` once per second.
- A second is defined as CLK_FREQ clock cycles.
- Prescaler divides `clk` down to a one-cycle tick; the tick advances the LED value.
- Sits at board top level driving the 8 user LEDs directly.

Parameters:
- CLK_FREQ, 50_000_000, input clock frequency in Hz = clk cycles per LED increment; legal range >= 1 (1 = increment every cycle).
- WIDTH, 8, LED counter width in bits; `leds` port width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high. Asserting it clears all state immediately; release is sampled by clk.
- leds  output  WIDTH  current count; drives the LEDs; registered output.
- tick  output  1  one-cycle pulse, high in the cycle the prescaler wraps (same edge `leds` advances); registered.

Behaviour:
- Reset (rst=1, asynchronous): prescaler=0, leds=0, tick=0; held while rst=1.
- Prescaler:
  - Width = max(1, $clog2(CLK_FREQ)).
  - Counts 0..CLK_FREQ-1, +1 per rising edge while rst=0.
  - At CLK_FREQ-1 it wraps to 0 on the next edge.
- Increment rule: on the edge where the prescaler goes CLK_FREQ-1 -> 0:
  - leds <= leds + 1.
  - tick <= 1 for exactly that one cycle.
  - tick = 0 on all other edges.
- Latency:
  - First increment on the CLK_FREQ-th rising edge after rst deasserts.
  - Subsequent increments every CLK_FREQ edges.
  - After N*CLK_FREQ edges, leds = N mod 2^WIDTH.
- Wrap-around: leds = 2^WIDTH-1 increments to 0, modulo arithmetic; no flag.
- Reset mid-count: prescaler and leds both clear. Partial prescaler progress is discarded, so the next increment is again a full CLK_FREQ edges after release.
- Reset asserted on the same edge as a wrap: reset wins; leds=0, tick=0.
- CLK_FREQ=1: prescaler is a constant 0; leds increments every edge; tick stays high continuously.
- No other inputs; no enable; counting is unconditional outside reset.

Optional Feature:
- Macro: LED_COUNTER_SATURATE_EN.
- Defined:
  - leds stops at 2^WIDTH-1 (all LEDs on) and holds until reset.
  - Prescaler keeps running.
  - tick still pulses every CLK_FREQ edges.
- Undefined (default): leds wraps 2^WIDTH-1 -> 0 as specified above.

Test Plan:
- CLK_FREQ=10, pulse rst, run 15 edges after release -> leds=1, tick pulsed once (at edge 10).
- CLK_FREQ=10, release rst, 5 edges, assert rst 1 cycle, release, run 10 edges -> leds=1 (partial count discarded); at 9 edges -> leds=0.
- CLK_FREQ=10, continue previous case 40 more edges (50 total since last reset) -> leds=5; tick high exactly 5 cycles total, each one cycle wide.
- CLK_FREQ=2, run 512 edges from reset -> leds wraps 255->0 at edge 512, leds=0. Same with LED_COUNTER_SATURATE_EN -> leds=255 and remains 255 after 20 more edges.
- Assert rst asynchronously mid-cycle (between clock edges) with leds=3 -> leds=0 and tick=0 immediately, before the next clk edge.
- CLK_FREQ=1, 7 edges after reset -> leds=7, tick constantly 1.
